// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshake, response, status and ALU-side signals for alu_arbiter.
// slave = arbiter view, master = requesters/ALU view.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CMD_W  = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_in1;
  logic [DATA_W-1:0] req0_in2;
  logic [DATA_W-1:0] req1_in1;
  logic [DATA_W-1:0] req1_in2;
  logic [CMD_W-1:0]  req0_cmd;
  logic [CMD_W-1:0]  req1_cmd;
  logic [1:0]        req_s;
  logic [1:0]        req_lock;

  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [CMD_W-1:0]  alu_cmd;
  logic              alu_c;
  logic [DATA_W-1:0] alu_out;
  logic              alu_n;
  logic              alu_z;
  logic              alu_c_o;
  logic              alu_v;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        status;
  logic              locked;

  modport slave (
    input  req_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_cmd, req1_cmd, req_s, req_lock,
           alu_out, alu_n, alu_z, alu_c_o, alu_v,
    output req_ready, alu_in1, alu_in2, alu_cmd, alu_c,
           rsp_valid, rsp_id, rsp_data, status, locked
  );

  modport master (
    output req_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_cmd, req1_cmd, req_s, req_lock,
           alu_out, alu_n, alu_z, alu_c_o, alu_v,
    input  req_ready, alu_in1, alu_in2, alu_cmd, alu_c,
           rsp_valid, rsp_id, rsp_data, status, locked
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one execute ALU between two requesters, with a
// lock for uninterrupted carry chains, a registered tagged result and the NZCV register.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CMD_W  = 4
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              lock_owner;
  logic              last_grant;
  logic              grant;
  logic              grant_valid;
  logic              sel_s;
  logic              sel_lock;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [3:0]        status_q;

  // Grant: a held lock excludes the other requester even while the owner idles.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (state == LOCKED) begin
      grant       = lock_owner;
      grant_valid = bus.req_valid[lock_owner];
    end else begin
      case (bus.req_valid)
        2'b01:   begin grant = 1'b0;        grant_valid = 1'b1; end
        2'b10:   begin grant = 1'b1;        grant_valid = 1'b1; end
        2'b11:   begin grant = ~last_grant; grant_valid = 1'b1; end
        default: begin grant = 1'b0;        grant_valid = 1'b0; end
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    bus.alu_cmd   = '0;
    sel_s         = 1'b0;
    sel_lock      = 1'b0;
    if (grant_valid) begin
      bus.req_ready[grant] = 1'b1;
      sel_s                = bus.req_s[grant];
      sel_lock             = bus.req_lock[grant];
      if (grant) begin
        bus.alu_in1 = bus.req1_in1;
        bus.alu_in2 = bus.req1_in2;
        bus.alu_cmd = bus.req1_cmd;
      end else begin
        bus.alu_in1 = bus.req0_in1;
        bus.alu_in2 = bus.req0_in2;
        bus.alu_cmd = bus.req0_cmd;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (grant_valid) begin
      case (state)
        UNLOCKED: if (sel_lock)  state_next = LOCKED;
        LOCKED:   if (!sel_lock) state_next = UNLOCKED;
        default:  state_next = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= UNLOCKED;
      lock_owner <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_valid && state == UNLOCKED && sel_lock)
        lock_owner <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      status_q    <= '0;
      last_grant  <= 1'b1;
    end else begin
      rsp_valid_q <= grant_valid;
      if (grant_valid) begin
        rsp_id_q   <= grant;
        rsp_data_q <= bus.alu_out;
        last_grant <= grant;
        if (sel_s)
          status_q <= {bus.alu_n, bus.alu_z, bus.alu_c_o, bus.alu_v};
      end
    end
  end

  assign bus.alu_c     = status_q[1];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.status    = status_q;
  assign bus.locked    = (state == LOCKED);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small behavioural ALU answers the arbiter,
// expected grants, results and flags are hand-computed constants.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_arbiter_if #(.DATA_W(32), .CMD_W(4)) bus ();

  alu_arbiter #(.DATA_W(32), .CMD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; subtraction reports C as borrow.
  logic [32:0] m_w;
  logic [31:0] m_r;
  logic        m_c;
  logic        m_v;
  always_comb begin
    m_w = '0;
    m_r = '0;
    m_c = bus.alu_c;
    m_v = 1'b0;
    case (bus.alu_cmd)
      4'd1: m_r = bus.alu_in2;
      4'd2, 4'd3: begin
        m_w = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2} +
              ((bus.alu_cmd == 4'd3) ? {32'd0, bus.alu_c} : 33'd0);
        m_r = m_w[31:0];
        m_c = m_w[32];
        m_v = (bus.alu_in1[31] == bus.alu_in2[31]) && (m_r[31] != bus.alu_in1[31]);
      end
      4'd4, 4'd5: begin
        m_w = {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2} -
              ((bus.alu_cmd == 4'd5) ? {32'd0, bus.alu_c} : 33'd0);
        m_r = m_w[31:0];
        m_c = m_w[32];
        m_v = (bus.alu_in1[31] != bus.alu_in2[31]) && (m_r[31] != bus.alu_in1[31]);
      end
      4'd6: m_r = bus.alu_in1 & bus.alu_in2;
      4'd7: m_r = bus.alu_in1 | bus.alu_in2;
      4'd8: m_r = bus.alu_in1 ^ bus.alu_in2;
      4'd9: m_r = ~bus.alu_in2;
      default: m_r = '0;
    endcase
  end

  assign bus.alu_out = m_r;
  assign bus.alu_n   = m_r[31];
  assign bus.alu_z   = (m_r == 32'd0);
  assign bus.alu_c_o = m_c;
  assign bus.alu_v   = m_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic lock);
    bus.req0_cmd    = cmd;
    bus.req0_in1    = a;
    bus.req0_in2    = b;
    bus.req_s[0]    = s;
    bus.req_lock[0] = lock;
  endtask

  task automatic drive1(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic lock);
    bus.req1_cmd    = cmd;
    bus.req1_in1    = a;
    bus.req1_in2    = b;
    bus.req_s[1]    = s;
    bus.req_lock[1] = lock;
  endtask

  initial begin
    logic exp_g;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req_valid = '0;
    drive0(4'd0, '0, '0, 1'b0, 1'b0);
    drive1(4'd0, '0, '0, 1'b0, 1'b0);

    #12;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_status",    64'(bus.status),    64'd0);
    check("rst_locked",    64'(bus.locked),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // ADD -12 + 20 with flags
    drive0(4'd2, 32'hFFFF_FFF4, 32'd20, 1'b1, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("add_ready",   64'(bus.req_ready), 64'h1);
    check("add_alu_cmd", 64'(bus.alu_cmd),   64'd2);
    check("add_alu_in1", 64'(bus.alu_in1),   64'hFFFF_FFF4);
    step();
    bus.req_valid = 2'b00;
    #1;
    check("add_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("add_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("add_rsp_data",  64'(bus.rsp_data),  64'd8);
    check("add_status",    64'(bus.status),    64'b0010);
    check("idle_ready",    64'(bus.req_ready), 64'd0);
    check("idle_alu_cmd",  64'(bus.alu_cmd),   64'd0);
    check("idle_alu_in2",  64'(bus.alu_in2),   64'd0);
    step();
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("idle_rsp_hold",  64'(bus.rsp_data),  64'd8);

    // Continuous contention: last grant was 0, so 1,0,1,0
    drive0(4'd1, 32'd0, 32'd5, 1'b0, 1'b0);
    drive1(4'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    exp_g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", 64'(bus.req_ready), exp_g ? 64'h2 : 64'h1);
      step();
      check("rr_rsp_id",   64'(bus.rsp_id),   64'(exp_g));
      check("rr_rsp_data", 64'(bus.rsp_data), exp_g ? 64'hFFFF_FFFF : 64'd5);
      exp_g = ~exp_g;
    end
    bus.req_valid = 2'b00;
    check("rr_status_hold", 64'(bus.status), 64'b0010);

    // SUB 5-5 sets Z; AND without s leaves flags alone
    drive1(4'd4, 32'd5, 32'd5, 1'b1, 1'b0);
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = 2'b00;
    check("sub_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("sub_status",   64'(bus.status),   64'b0100);
    drive0(4'd6, 32'd3, 32'd1, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    check("and_rsp_data", 64'(bus.rsp_data), 64'd1);
    check("and_status",   64'(bus.status),   64'b0100);

    // Lock chain ADD(lock) -> ADC(unlock) from requester 1, requester 0 waiting
    drive0(4'd1, 32'd0, 32'd7, 1'b0, 1'b0);
    drive1(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
    bus.req_valid = 2'b11;
    #1;
    check("lk_add_ready", 64'(bus.req_ready), 64'h2);
    check("lk_pre_locked", 64'(bus.locked),  64'd0);
    step();
    drive1(4'd3, 32'd10, 32'd20, 1'b1, 1'b0);
    #1;
    check("lk_locked",     64'(bus.locked),   64'd1);
    check("lk_adc_ready",  64'(bus.req_ready), 64'h2);
    check("lk_adc_alu_c",  64'(bus.alu_c),    64'd1);
    check("lk_add_data",   64'(bus.rsp_data), 64'd1);
    check("lk_add_status", 64'(bus.status),   64'b0010);
    step();
    bus.req_valid = 2'b01;
    #1;
    check("lk_released",   64'(bus.locked),   64'd0);
    check("lk_adc_data",   64'(bus.rsp_data), 64'd31);
    check("lk_adc_status", 64'(bus.status),   64'b0000);
    check("lk_req0_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 2'b00;
    check("lk_req0_id",   64'(bus.rsp_id),   64'd0);
    check("lk_req0_data", 64'(bus.rsp_data), 64'd7);

    // Locked owner goes idle for two cycles; requester 0 must stay blocked
    drive0(4'd1, 32'd0, 32'd9, 1'b0, 1'b0);
    drive1(4'd2, 32'd1, 32'd1, 1'b0, 1'b1);
    bus.req_valid = 2'b11;
    #1;
    check("idle_lk_ready", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = 2'b01;
    #1;
    check("idle_lk_locked", 64'(bus.locked),    64'd1);
    check("idle_lk_rdy1",   64'(bus.req_ready), 64'h0);
    step();
    check("idle_lk_rv1",    64'(bus.rsp_valid), 64'd0);
    check("idle_lk_rdy2",   64'(bus.req_ready), 64'h0);
    step();
    check("idle_lk_rv2",    64'(bus.rsp_valid), 64'd0);
    check("idle_lk_still",  64'(bus.locked),    64'd1);
    drive1(4'd2, 32'd2, 32'd3, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    check("idle_lk_resume", 64'(bus.req_ready), 64'h2);
    step();
    #1;
    check("idle_lk_data",   64'(bus.rsp_data),  64'd5);
    check("idle_lk_unlock", 64'(bus.locked),    64'd0);
    check("idle_lk_req0",   64'(bus.req_ready), 64'h1);
    bus.req_valid = 2'b00;
    step();

    // Asynchronous reset during a locked chain with a response pending
    drive1(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    bus.req_valid = 2'b10;
    step();
    drive1(4'd3, 32'd1, 32'd1, 1'b1, 1'b1);
    bus.req_valid = 2'b11;
    check("ar_pre_valid",  64'(bus.rsp_valid), 64'd1);
    check("ar_pre_locked", 64'(bus.locked),    64'd1);
    check("ar_pre_status", 64'(bus.status),    64'b0110);
    #2;
    rst = 1'b0;
    #1;
    check("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("ar_locked",    64'(bus.locked),    64'd0);
    check("ar_status",    64'(bus.status),    64'd0);
    check("ar_rsp_data",  64'(bus.rsp_data),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive1(4'd1, 32'd0, 32'd4, 1'b0, 1'b0);
    #1;
    check("ar_first_grant", 64'(bus.req_ready), 64'h1);
    step();
    check("ar_first_id",   64'(bus.rsp_id),   64'd0);
    check("ar_first_data", 64'(bus.rsp_data), 64'd9);
    bus.req_valid = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
